dpram_bist_ctrl: RTL and testbench

Self-checking built-in test controller for the true-dual-port histogram RAMs. It drives both RAM ports from a single clock and runs four write/read-back phases covering every write-port/read-port pairing. Every read word is compared against the expected pattern, and the controller reports a saturating error count plus a pass flag. Address width, data width and read latency are parameters, so one block covers the registered and unregistered RAM variants in the design.

---
 rtl/dpram_bist_ctrl.sv | 197 +++++++++++++++++++
 tb/tb_dpram_bist_ctrl.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/dpram_bist_ctrl.sv
// Write/read-back BIST controller for the true-dual-port histogram RAMs; sweeps all four port pairings.
// Optional build macro DPRAM_BIST_INVERT_PASS_EN: phases 1 and 3 use the inverted data pattern.
module dpram_bist_ctrl #(
   parameter int unsigned ADDR_WIDTH    = 8,
   parameter int unsigned DATA_WIDTH    = 32,
   parameter int unsigned RD_LATENCY    = 1,
   parameter int unsigned ERR_CNT_WIDTH = 4
) (
   input  logic                     a_clk,
   input  logic                     tb_a_rst,
   input  logic                     start,
   output logic [ADDR_WIDTH-1:0]    a_addr,
   output logic [DATA_WIDTH-1:0]    a_wr_data,
   output logic                     a_wr_en,
   input  logic [DATA_WIDTH-1:0]    a_rd_data,
   output logic [ADDR_WIDTH-1:0]    b_addr,
   output logic [DATA_WIDTH-1:0]    b_wr_data,
   output logic                     b_wr_en,
   input  logic [DATA_WIDTH-1:0]    b_rd_data,
   output logic                     busy,
   output logic                     done,
   output logic                     pass,
   output logic [ERR_CNT_WIDTH-1:0] err_cnt,
   output logic [1:0]               phase
);

   localparam logic [ADDR_WIDTH-1:0]    ADDR_MAX   = '1;
   localparam logic [ERR_CNT_WIDTH-1:0] ERR_MAX    = '1;
   localparam logic [1:0]               DRAIN_LAST = 2'(RD_LATENCY - 1);

   typedef enum logic [2:0] {S_IDLE, S_WRITE, S_READ, S_DRAIN, S_DONE} state_e;

   state_e                   state_q;
   logic [ADDR_WIDTH-1:0]    cnt_q;
   logic [1:0]               phase_q;
   logic [1:0]               drain_q;
   logic [ERR_CNT_WIDTH-1:0] err_q, err_d;
   logic                     busy_q, done_q, pass_q;
   logic [ADDR_WIDTH-1:0]    a_addr_q, b_addr_q;
   logic [DATA_WIDTH-1:0]    a_wr_data_q, b_wr_data_q;
   logic                     a_wr_en_q, b_wr_en_q;
   logic [RD_LATENCY-1:0]    vld_q;
   logic [DATA_WIDTH-1:0]    pat_q [RD_LATENCY];

   logic                     wr_b_c, rd_b_c, nwr_b_c, inv_c, ninv_c, mism_c;
   logic [ADDR_WIDTH-1:0]    nxt_addr_c;
   logic [DATA_WIDTH-1:0]    nxt_pat_c, rd_sel_c;

   // pattern(i) = all-ones minus i, i.e. the bitwise complement of i at DATA_WIDTH bits
   function automatic logic [DATA_WIDTH-1:0] pattern(input logic [ADDR_WIDTH-1:0] idx,
                                                     input logic inv);
      logic [DATA_WIDTH-1:0] p;
      p = ~DATA_WIDTH'(idx);
      return inv ? ~p : p;
   endfunction

`ifdef DPRAM_BIST_INVERT_PASS_EN
   assign inv_c  = phase_q[0];
   assign ninv_c = ~phase_q[0];
`else
   assign inv_c  = 1'b0;
   assign ninv_c = 1'b0;
`endif

   // Phase map write/read: 0 A/A, 1 A/B, 2 B/B, 3 B/A
   assign wr_b_c     = phase_q[1];
   assign rd_b_c     = phase_q[1] ^ phase_q[0];
   assign nwr_b_c    = (phase_q != 2'd0);
   assign nxt_addr_c = cnt_q + ADDR_WIDTH'(1);
   assign nxt_pat_c  = pattern(nxt_addr_c, inv_c);
   assign rd_sel_c   = rd_b_c ? b_rd_data : a_rd_data;
   assign mism_c     = vld_q[RD_LATENCY-1] && (rd_sel_c != pat_q[RD_LATENCY-1]);
   assign err_d      = (mism_c && (err_q != ERR_MAX)) ? err_q + ERR_CNT_WIDTH'(1) : err_q;

   // Read-valid pipeline aligned with RAM read latency
   always_ff @(posedge a_clk or posedge tb_a_rst) begin
      if (tb_a_rst) begin
         vld_q <= '0;
      end else begin
         vld_q[0] <= (state_q == S_READ);
         for (int unsigned j = 1; j < RD_LATENCY; j++) vld_q[j] <= vld_q[j-1];
      end
   end

   always_ff @(posedge a_clk) begin
      pat_q[0] <= pattern(cnt_q, inv_c);
      for (int unsigned j = 1; j < RD_LATENCY; j++) pat_q[j] <= pat_q[j-1];
   end

   // Controller FSM; port outputs default to idle and are driven for the upcoming cycle
   always_ff @(posedge a_clk or posedge tb_a_rst) begin
      if (tb_a_rst) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         phase_q     <= '0;
         drain_q     <= '0;
         err_q       <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         pass_q      <= 1'b0;
         a_addr_q    <= '0;
         a_wr_data_q <= '0;
         a_wr_en_q   <= 1'b0;
         b_addr_q    <= '0;
         b_wr_data_q <= '0;
         b_wr_en_q   <= 1'b0;
      end else begin
         a_addr_q    <= '0;
         a_wr_data_q <= '0;
         a_wr_en_q   <= 1'b0;
         b_addr_q    <= '0;
         b_wr_data_q <= '0;
         b_wr_en_q   <= 1'b0;
         err_q       <= err_d;
         case (state_q)
            S_IDLE, S_DONE: begin
               if (start) begin
                  state_q     <= S_WRITE;
                  cnt_q       <= '0;
                  phase_q     <= '0;
                  err_q       <= '0;
                  busy_q      <= 1'b1;
                  done_q      <= 1'b0;
                  pass_q      <= 1'b0;
                  a_wr_en_q   <= 1'b1;
                  a_wr_data_q <= '1;
               end
            end
            S_WRITE: begin
               if (cnt_q == ADDR_MAX) begin
                  state_q <= S_READ;
                  cnt_q   <= '0;
               end else begin
                  cnt_q <= nxt_addr_c;
                  if (wr_b_c) begin
                     b_addr_q    <= nxt_addr_c;
                     b_wr_en_q   <= 1'b1;
                     b_wr_data_q <= nxt_pat_c;
                  end else begin
                     a_addr_q    <= nxt_addr_c;
                     a_wr_en_q   <= 1'b1;
                     a_wr_data_q <= nxt_pat_c;
                  end
               end
            end
            S_READ: begin
               if (cnt_q == ADDR_MAX) begin
                  state_q <= S_DRAIN;
                  cnt_q   <= '0;
                  drain_q <= '0;
               end else begin
                  cnt_q <= nxt_addr_c;
                  if (rd_b_c) b_addr_q <= nxt_addr_c;
                  else        a_addr_q <= nxt_addr_c;
               end
            end
            S_DRAIN: begin
               if (drain_q == DRAIN_LAST) begin
                  if (phase_q == 2'd3) begin
                     state_q <= S_DONE;
                     busy_q  <= 1'b0;
                     done_q  <= 1'b1;
                     pass_q  <= (err_d == '0);
                  end else begin
                     state_q <= S_WRITE;
                     phase_q <= phase_q + 2'd1;
                     cnt_q   <= '0;
                     if (nwr_b_c) begin
                        b_wr_en_q   <= 1'b1;
                        b_wr_data_q <= ninv_c ? '0 : '1;
                     end else begin
                        a_wr_en_q   <= 1'b1;
                        a_wr_data_q <= ninv_c ? '0 : '1;
                     end
                  end
               end else begin
                  drain_q <= drain_q + 2'd1;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign a_addr    = a_addr_q;
   assign a_wr_data = a_wr_data_q;
   assign a_wr_en   = a_wr_en_q;
   assign b_addr    = b_addr_q;
   assign b_wr_data = b_wr_data_q;
   assign b_wr_en   = b_wr_en_q;
   assign busy      = busy_q;
   assign done      = done_q;
   assign pass      = pass_q;
   assign err_cnt   = err_q;
   assign phase     = phase_q;

endmodule

// File: tb/tb_dpram_bist_ctrl.sv
// Directed bench for dpram_bist_ctrl: ideal and faulty dual-port RAM models, RD_LATENCY 1 and 2.
module tb_dpram_bist_ctrl;

   logic        a_clk = 1'b0;
   logic        tb_a_rst;
   logic        start1, start2;
   int          checks = 0;
   int          errors = 0;

   // DUT1: RD_LATENCY=1
   logic [7:0]  a_addr1, b_addr1;
   logic [31:0] a_wr_data1, b_wr_data1, a_rd1, b_rd1;
   logic        a_wr_en1, b_wr_en1, busy1, done1, pass1;
   logic [3:0]  err1;
   logic [1:0]  phase1;
   // DUT2: RD_LATENCY=2
   logic [7:0]  a_addr2, b_addr2;
   logic [31:0] a_wr_data2, b_wr_data2, a_rd2, b_rd2;
   logic        a_wr_en2, b_wr_en2, busy2, done2, pass2;
   logic [3:0]  err2;
   logic [1:0]  phase2;

   logic        reg_mode, flip_b, stuck_a5;
   logic [31:0] mem1 [256];
   logic [31:0] mem2 [256];
   logic [31:0] ra1, rb1, ra1r, rb1r, ra2, rb2, ra2r, rb2r;
   logic [7:0]  rbaddr1;

   int          cyc, last_ph;
   int          ph_t [4];
   logic [31:0] w7;
   logic [3:0]  err_p1;

   always #5 a_clk = ~a_clk;

   dpram_bist_ctrl #(.ADDR_WIDTH(8), .DATA_WIDTH(32), .RD_LATENCY(1), .ERR_CNT_WIDTH(4)) u_dut1 (
      .a_clk(a_clk), .tb_a_rst(tb_a_rst), .start(start1),
      .a_addr(a_addr1), .a_wr_data(a_wr_data1), .a_wr_en(a_wr_en1), .a_rd_data(a_rd1),
      .b_addr(b_addr1), .b_wr_data(b_wr_data1), .b_wr_en(b_wr_en1), .b_rd_data(b_rd1),
      .busy(busy1), .done(done1), .pass(pass1), .err_cnt(err1), .phase(phase1));

   dpram_bist_ctrl #(.ADDR_WIDTH(8), .DATA_WIDTH(32), .RD_LATENCY(2), .ERR_CNT_WIDTH(4)) u_dut2 (
      .a_clk(a_clk), .tb_a_rst(tb_a_rst), .start(start2),
      .a_addr(a_addr2), .a_wr_data(a_wr_data2), .a_wr_en(a_wr_en2), .a_rd_data(a_rd2),
      .b_addr(b_addr2), .b_wr_data(b_wr_data2), .b_wr_en(b_wr_en2), .b_rd_data(b_rd2),
      .busy(busy2), .done(done2), .pass(pass2), .err_cnt(err2), .phase(phase2));

   // Behavioural dual-port RAMs: synchronous read, optional output register
   always @(posedge a_clk) begin
      if (a_wr_en1) mem1[a_addr1] <= a_wr_data1;
      if (b_wr_en1) mem1[b_addr1] <= b_wr_data1;
      ra1     <= mem1[a_addr1];
      rb1     <= mem1[b_addr1];
      rbaddr1 <= b_addr1;
      ra1r    <= ra1;
      rb1r    <= rb1;
   end
   assign a_rd1 = (reg_mode ? ra1r : ra1) & ~(stuck_a5 ? 32'h20 : 32'h0);
   assign b_rd1 = (reg_mode ? rb1r : rb1) ^ {31'b0, flip_b && (rbaddr1 == 8'h10)};

   always @(posedge a_clk) begin
      if (a_wr_en2) mem2[a_addr2] <= a_wr_data2;
      if (b_wr_en2) mem2[b_addr2] <= b_wr_data2;
      ra2  <= mem2[a_addr2];
      rb2  <= mem2[b_addr2];
      ra2r <= ra2;
      rb2r <= rb2;
   end
   assign a_rd2 = ra2r;
   assign b_rd2 = rb2r;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic pulse1();
      start1 = 1'b1;
      @(posedge a_clk); #1;
      start1 = 1'b0;
   endtask

   // Wait for DUT1 to finish (bounded); optionally pokes start at cycle poke_at
   task automatic wait1(input int poke_at);
      cyc = 0; last_ph = 0; w7 = '0; err_p1 = '0;
      for (int i = 0; i < 4; i++) ph_t[i] = 0;
      while (busy1 && cyc < 3000) begin
         if (cyc == poke_at) start1 = 1'b1;
         @(posedge a_clk); #1;
         start1 = 1'b0;
         cyc++;
         if (int'(phase1) != last_ph) begin
            last_ph = int'(phase1);
            ph_t[last_ph] = cyc;
            if (phase1 == 2'd1) err_p1 = err1;
         end
         if (phase1 == 2'd1 && a_wr_en1 && a_addr1 == 8'h07) w7 = a_wr_data1;
      end
   endtask

   initial begin
      tb_a_rst = 1'b1; start1 = 1'b0; start2 = 1'b0;
      reg_mode = 1'b0; flip_b = 1'b0; stuck_a5 = 1'b0;
      #12;
      chk("rst_ctrl", 64'({busy1, done1, pass1, a_wr_en1, b_wr_en1, phase1, err1}), 64'h0);
      chk("rst_addr_data", 64'({a_addr1, b_addr1, a_wr_data1 | b_wr_data1}), 64'h0);
      tb_a_rst = 1'b0;
      repeat (2) @(posedge a_clk);
      #1;

      // Clean run
      pulse1();
      chk("start_ctrl", 64'({busy1, done1, a_wr_en1, b_wr_en1, phase1}), 64'b1_0_1_0_00);
      chk("start_word", 64'({a_addr1, a_wr_data1}), 64'h00_FFFFFFFF);
      wait1(-1);
      chk("clean_busy_cycles", 64'(cyc), 64'd2052);
      chk("clean_phase_times", 64'({16'(ph_t[1]), 16'(ph_t[2]), 16'(ph_t[3])}),
          64'({16'd513, 16'd1026, 16'd1539}));
      chk("clean_result", 64'({busy1, done1, pass1, err1}), 64'b0_1_1_0000);
`ifdef DPRAM_BIST_INVERT_PASS_EN
      chk("ph1_wdata_addr7", 64'(w7), 64'h0000_0007);
`else
      chk("ph1_wdata_addr7", 64'(w7), 64'hFFFF_FFF8);
`endif

      // One flipped bit on port B at address 0x10
      flip_b = 1'b1;
      pulse1();
      chk("restart_clears_done", 64'({done1, pass1, busy1}), 64'b0_0_1);
      wait1(-1);
      chk("flip_result", 64'({done1, pass1, err1}), 64'({1'b1, 1'b0, 4'd2}));
      flip_b = 1'b0;

      // Port A bit 5 stuck at 0: saturates in phase 0
      stuck_a5 = 1'b1;
      pulse1();
      wait1(-1);
      chk("stuck_err_end_ph0", 64'(err_p1), 64'd15);
      chk("stuck_result", 64'({done1, pass1, err1}), 64'({1'b1, 1'b0, 4'd15}));
      stuck_a5 = 1'b0;

      // Registered RAM output against a latency-1 controller
      reg_mode = 1'b1;
      pulse1();
      wait1(-1);
      chk("lat_mismatch_err", 64'({done1, pass1, err1}), 64'({1'b1, 1'b0, 4'd15}));
      reg_mode = 1'b0;

      // Start pulse mid-run is ignored
      pulse1();
      wait1(100);
      chk("poke_busy_cycles", 64'(cyc), 64'd2052);
      chk("poke_phase_times", 64'({16'(ph_t[1]), 16'(ph_t[2]), 16'(ph_t[3])}),
          64'({16'd513, 16'd1026, 16'd1539}));
      chk("poke_result", 64'({done1, pass1, err1}), 64'({1'b1, 1'b1, 4'd0}));

      // Reset mid-run aborts immediately
      pulse1();
      repeat (300) @(posedge a_clk);
      #1;
      chk("abort_pre_busy", 64'(busy1), 64'd1);
      tb_a_rst = 1'b1;
      #1;
      chk("abort_ctrl", 64'({busy1, done1, pass1, a_wr_en1, b_wr_en1, phase1, err1}), 64'h0);
      chk("abort_addr_data", 64'({a_addr1, b_addr1, a_wr_data1 | b_wr_data1}), 64'h0);
      #1;
      tb_a_rst = 1'b0;
      repeat (3) @(posedge a_clk);
      #1;
      chk("abort_stays_idle", 64'({busy1, done1}), 64'h0);
      pulse1();
      wait1(-1);
      chk("after_abort_cycles", 64'(cyc), 64'd2052);
      chk("after_abort_result", 64'({done1, pass1, err1}), 64'({1'b1, 1'b1, 4'd0}));

      // RD_LATENCY=2 controller with registered RAM
      start2 = 1'b1;
      @(posedge a_clk); #1;
      start2 = 1'b0;
      chk("lat2_start_busy", 64'(busy2), 64'd1);
      cyc = 0;
      while (busy2 && cyc < 3000) begin
         @(posedge a_clk); #1;
         cyc++;
      end
      chk("lat2_busy_cycles", 64'(cyc), 64'd2056);
      chk("lat2_result", 64'({done2, pass2, err2}), 64'({1'b1, 1'b1, 4'd0}));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
